qspi_ram_responder: RTL and testbench
=====================================

Name: qspi_ram_responder

Overview:
- Synthesizable quad-SPI responder emulating the external SPI RAM that the CPU memory controller talks to.
- Lets the CPU-side master be tested on-chip and in simulation without a device model.
- Oversamples the incoming SPI clock, chip select and data on the system clock.
- Decodes a 1-byte command and a 24-bit address, then serves byte reads/writes from an internal byte array with address auto-increment.

Parameters:
- ADDRESS_WIDTH, 8, internal array holds 2^ADDRESS_WIDTH bytes; received address truncated to low ADDRESS_WIDTH bits.
- DUMMY_CYCLES, 4, SPI clock rising edges between the last address nibble and the first read-data nibble.

Ports:
- clock  input  1  system clock, must be >= 4x spi_clk_in frequency.
- reset  input  1  asynchronous, active-low.
- spi_clk_in  input  1  SPI clock from master, mode 0 (idle low).
- spi_select  input  1  chip select, active-low.
- spi_data_in  input  4  quad data from master.
- spi_data_out  output  4  quad data to master.
- spi_data_oe  output  4  per-lane output enable (all-ones or all-zeros).
- busy  output  1  high while select is asserted (synchronized).
- cmd_error  output  1  one-cycle pulse when an unsupported command byte completes.
- host_addr  input  ADDRESS_WIDTH  debug read address into the array.
- host_rdata  output  8  combinational array[host_addr].

Behaviour:
- Reset (reset=0, async): state IDLE; spi_data_out=0, spi_data_oe=0, busy=0, cmd_error=0; counters and address register 0. Array contents are not reset.
- Synchronization: spi_clk_in, spi_select and spi_data_in each pass through two flops.
- Edge detection: rise/fall pulses come from the synchronized clock vs. its previous sample. All SPI actions happen on these pulses, never on raw inputs.
- Sampling and driving: data is sampled on rise; output nibbles change on fall. Nibble order is high nibble first; address is MSB nibble first.
- Select deasserted (synchronized high) in any state → IDLE next cycle, with oe=0, nibble counter cleared and any partial write byte discarded. This takes priority over edges in the same cycle.
- IDLE → CMD on select assert.
- CMD: 2 rises assemble the command byte.
  - 0x03 → ADDR (read).
  - 0x02 → ADDR (write).
  - Anything else → IGNORE, with cmd_error pulsed for 1 cycle.
- ADDR: 6 rises assemble 24 bits; the low ADDRESS_WIDTH bits load addr_reg.
  - Read: → DUMMY, or READ directly if DUMMY_CYCLES=0.
  - Write: → WRITE.
- DUMMY: count DUMMY_CYCLES rises, then → READ. oe stays 0.
- READ:
  - On each fall: drive the next nibble of array[addr_reg] and set oe=4'hF. The first fall in READ drives the high nibble.
  - After the low nibble is driven, addr_reg increments on the following rise.
  - Wrap 2^ADDRESS_WIDTH-1 → 0.
  - oe stays high until deselect.
- WRITE:
  - The high nibble is captured on its rise.
  - On the low-nibble rise, the byte is written to array[addr_reg] and addr_reg increments (with wrap).
  - Streaming is unlimited.
- IGNORE: all edges ignored until deselect; oe=0.
- A new select assertion after deselect always starts at CMD; there is no continuation mode.
- busy = synchronized select inverted, registered.
- Same-cycle write commit and host_addr read of the same location: host_rdata shows the old value that cycle, the new value the next.

Test Plan:
- Reset: assert reset=0 mid-READ with oe=F → oe, spi_data_out, busy and cmd_error go 0 immediately, without a clock edge. After release, next select starts in CMD.
- Write: send cmd 0x02, addr 0x000010, data 0xA5 0x3C → host_addr=0x10 reads 0xA5; host_addr=0x11 reads 0x3C.
- Read with DUMMY_CYCLES=4: send cmd 0x03, addr 0x000010 → oe=0 for 4 dummy clocks, then nibbles A,5,3,C appear on successive falls with oe=F.
- Wrap at ADDRESS_WIDTH=8: write 0x11, 0x22 starting at 0x0000FF → array[0xFF]=0x11, array[0x00]=0x22. Reading from 0xFF returns the same bytes.
- Abort: deselect after the first data nibble of a write to 0x20 → array[0x20] unchanged, state IDLE, oe=0. A following read of 0x20 works normally.
- Bad command: send 0x9F → cmd_error pulses exactly 1 cycle; oe stays 0 for the rest of the transaction; array unchanged.

Source files
------------

// File: rtl/qspi_ram_responder.sv
// Quad-SPI RAM responder: oversamples a mode-0 SPI master on the system clock and
// serves byte reads (cmd 0x03) and writes (cmd 0x02) from an internal byte array.
module qspi_ram_responder #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DUMMY_CYCLES  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     spi_clk_in,
  input  logic                     spi_select,
  input  logic [3:0]               spi_data_in,
  output logic [3:0]               spi_data_out,
  output logic [3:0]               spi_data_oe,
  output logic                     busy,
  output logic                     cmd_error,
  input  logic [ADDRESS_WIDTH-1:0] host_addr,
  output logic [7:0]               host_rdata
);

  localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;
  localparam int unsigned CntW  = (DUMMY_CYCLES > 7) ? $clog2(DUMMY_CYCLES + 1) : 3;
  // Shift width covers both the command byte and the retained address bits.
  localparam int unsigned ShW   = (ADDRESS_WIDTH > 8) ? ADDRESS_WIDTH : 8;

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDummy, StRead, StWrite, StIgnore
  } state_e;

  logic [1:0]               clk_sync_q, sel_sync_q;
  logic [3:0]               din_s1_q, din_s2_q;
  logic                     clk_prev_q;
  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [ShW-5:0]           shift_q, shift_d;
  logic [ShW-1:0]           shift_nxt;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     wr_mode_q, wr_mode_d;
  logic [3:0]               dout_q, dout_d;
  logic [3:0]               oe_q, oe_d;
  logic                     cmd_err_q, cmd_err_d;
  logic                     busy_q;
  logic                     mem_we;
  logic [7:0]               mem_wdata;
  logic [7:0]               mem_rbyte;
  logic [7:0]               mem_q [Depth];

  logic rise, fall, sel_n;
  assign rise  = clk_sync_q[1] & ~clk_prev_q;
  assign fall  = ~clk_sync_q[1] & clk_prev_q;
  assign sel_n = sel_sync_q[1];

  assign shift_nxt = {shift_q, din_s2_q};
  assign mem_rbyte = mem_q[addr_q];

  // Two-flop synchronizers and the previous clock sample used for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= 2'b00;
      sel_sync_q <= 2'b11;
      din_s1_q   <= 4'h0;
      din_s2_q   <= 4'h0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], spi_clk_in};
      sel_sync_q <= {sel_sync_q[0], spi_select};
      din_s1_q   <= spi_data_in;
      din_s2_q   <= din_s1_q;
      clk_prev_q <= clk_sync_q[1];
    end
  end

  // Protocol next-state: deselect overrides everything, otherwise act on SPI edges only.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wr_mode_d = wr_mode_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    cmd_err_d = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = {shift_q[3:0], din_s2_q};
    if (sel_n) begin
      state_d = StIdle;
      cnt_d   = '0;
      oe_d    = 4'h0;
      dout_d  = 4'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StCmd;
          cnt_d   = '0;
        end
        StCmd: if (rise) begin
          shift_d = shift_nxt[ShW-5:0];
          if (cnt_q == CntW'(1)) begin
            cnt_d = '0;
            case (shift_nxt[7:0])
              8'h03: begin state_d = StAddr; wr_mode_d = 1'b0; end
              8'h02: begin state_d = StAddr; wr_mode_d = 1'b1; end
              default: begin state_d = StIgnore; cmd_err_d = 1'b1; end
            endcase
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StAddr: if (rise) begin
          shift_d = shift_nxt[ShW-5:0];
          if (cnt_q == CntW'(5)) begin
            cnt_d  = '0;
            addr_d = shift_nxt[ADDRESS_WIDTH-1:0];
            if (wr_mode_q)              state_d = StWrite;
            else if (DUMMY_CYCLES == 0) state_d = StRead;
            else                        state_d = StDummy;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDummy: if (rise) begin
          if (cnt_q == CntW'(DUMMY_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = StRead;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        // cnt: 0 = high nibble next, 1 = low nibble next, 2 = byte done, bump on rise.
        StRead: begin
          if (fall && cnt_q == CntW'(0)) begin
            dout_d = mem_rbyte[7:4];
            oe_d   = 4'hF;
            cnt_d  = CntW'(1);
          end else if (fall && cnt_q == CntW'(1)) begin
            dout_d = mem_rbyte[3:0];
            oe_d   = 4'hF;
            cnt_d  = CntW'(2);
          end else if (rise && cnt_q == CntW'(2)) begin
            addr_d = addr_q + ADDRESS_WIDTH'(1);
            cnt_d  = '0;
          end
        end
        StWrite: if (rise) begin
          if (cnt_q == CntW'(0)) begin
            shift_d = shift_nxt[ShW-5:0];
            cnt_d   = CntW'(1);
          end else begin
            mem_we = 1'b1;
            addr_d = addr_q + ADDRESS_WIDTH'(1);
            cnt_d  = '0;
          end
        end
        StIgnore: oe_d = 4'h0;
        default: state_d = StIdle;
      endcase
    end
  end

  // Protocol state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wr_mode_q <= 1'b0;
      dout_q    <= 4'h0;
      oe_q      <= 4'h0;
      cmd_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wr_mode_q <= wr_mode_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      cmd_err_q <= cmd_err_d;
      busy_q    <= ~sel_n;
    end
  end

  // Byte array; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[addr_q] <= mem_wdata;
  end

  assign spi_data_out = dout_q;
  assign spi_data_oe  = oe_q;
  assign busy         = busy_q;
  assign cmd_error    = cmd_err_q;
  assign host_rdata   = mem_q[host_addr];

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Randomized bench for qspi_ram_responder: a transaction-level master plus a byte-array
// model; read nibbles are checked at every master sample point.
module tb_qspi_ram_responder;

  localparam int unsigned AW   = 8;
  localparam int unsigned DC   = 4;
  localparam int          HALF = 4;  // system cycles per SPI half period

  logic          clock = 1'b0;
  logic          reset;
  logic          spi_clk_in;
  logic          spi_select;
  logic [3:0]    spi_data_in;
  logic [3:0]    spi_data_out;
  logic [3:0]    spi_data_oe;
  logic          busy;
  logic          cmd_error;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_rdata;

  qspi_ram_responder #(
    .ADDRESS_WIDTH(AW),
    .DUMMY_CYCLES (DC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .spi_clk_in  (spi_clk_in),
    .spi_select  (spi_select),
    .spi_data_in (spi_data_in),
    .spi_data_out(spi_data_out),
    .spi_data_oe (spi_data_oe),
    .busy        (busy),
    .cmd_error   (cmd_error),
    .host_addr   (host_addr),
    .host_rdata  (host_rdata)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         err_cycles = 0;
  bit         chk_en = 1'b0;
  logic [3:0] exp_oe = 4'h0;
  logic [3:0] exp_nib = 4'h0;
  logic [7:0] model_mem [256];
  logic [7:0] wr_q [$];
  logic [7:0] rd_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master sample point: outputs must match what the model says this rise should see.
  always @(posedge spi_clk_in) begin
    if (chk_en) begin
      check("busy_in_txn", 32'(busy), 32'(1));
      check("oe_at_rise", 32'(spi_data_oe), 32'(exp_oe));
      if (exp_oe == 4'hF) check("read_nibble", 32'(spi_data_out), 32'(exp_nib));
    end
  end

  always @(negedge clock) begin
    if (cmd_error === 1'b1) err_cycles++;
  end

  function automatic logic [7:0] a8(input logic [23:0] base, input int off);
    return 8'(base + 24'(off));
  endfunction

  task automatic nib(input logic [3:0] din, input logic [3:0] e_oe, input logic [3:0] e_nib,
                     output logic [3:0] got);
    spi_data_in = din;
    exp_oe      = e_oe;
    exp_nib     = e_nib;
    chk_en      = 1'b1;
    repeat (HALF) @(negedge clock);
    spi_clk_in = 1'b1;
    got        = spi_data_out;
    repeat (HALF) @(negedge clock);
    spi_clk_in = 1'b0;
  endtask

  task automatic begin_txn();
    err_cycles = 0;
    spi_select = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic end_txn(input int exp_err);
    chk_en     = 1'b0;
    spi_select = 1'b1;
    repeat (8) @(negedge clock);
    check("busy_after_desel", 32'(busy), 32'(0));
    check("oe_after_desel", 32'(spi_data_oe), 32'(0));
    check("cmd_error_cycles", 32'(err_cycles), 32'(exp_err));
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [3:0]  g;
    logic [31:0] w;
    w = {cmd, addr};
    for (int i = 7; i >= 0; i--) nib(w[i*4 +: 4], 4'h0, 4'h0, g);
  endtask

  // Writes wr_q from addr; with abort set, only the first nibble is sent.
  task automatic write_txn(input logic [23:0] addr, input bit abort);
    logic [3:0] g;
    begin_txn();
    send_hdr(8'h02, addr);
    if (abort) begin
      nib(wr_q[0][7:4], 4'h0, 4'h0, g);
    end else begin
      foreach (wr_q[i]) begin
        nib(wr_q[i][7:4], 4'h0, 4'h0, g);
        nib(wr_q[i][3:0], 4'h0, 4'h0, g);
      end
    end
    end_txn(0);
    if (!abort) foreach (wr_q[i]) model_mem[a8(addr, i)] = wr_q[i];
  endtask

  task automatic read_body(input logic [23:0] addr, input int nbytes);
    logic [3:0] g;
    logic [7:0] b, cur;
    rd_q.delete();
    cur = 8'h00;
    send_hdr(8'h03, addr);
    for (int i = 0; i < int'(DC); i++) nib(4'($urandom), 4'h0, 4'h0, g);
    for (int i = 0; i < 2 * nbytes; i++) begin
      b = model_mem[a8(addr, i / 2)];
      nib(4'($urandom), 4'hF, (i % 2 == 0) ? b[7:4] : b[3:0], g);
      if (i % 2 == 0) cur[7:4] = g;
      else begin
        cur[3:0] = g;
        rd_q.push_back(cur);
      end
    end
  endtask

  task automatic read_txn(input logic [23:0] addr, input int nbytes);
    begin_txn();
    read_body(addr, nbytes);
    end_txn(0);
  endtask

  task automatic bad_txn(input logic [7:0] cmd, input int extra);
    logic [3:0] g;
    begin_txn();
    nib(cmd[7:4], 4'h0, 4'h0, g);
    nib(cmd[3:0], 4'h0, 4'h0, g);
    for (int i = 0; i < extra; i++) nib(4'($urandom), 4'h0, 4'h0, g);
    end_txn(1);
  endtask

  task automatic host_check(input string name, input logic [7:0] a, input logic [7:0] lit);
    @(negedge clock);
    host_addr = a;
    #1;
    check(name, 32'(host_rdata), 32'(lit));
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 256; a++) begin
      @(negedge clock);
      host_addr = 8'(a);
      #1;
      check($sformatf("%s[%0h]", tag, a), 32'(host_rdata), 32'(model_mem[a]));
    end
  endtask

  initial begin
    logic [7:0] c;
    int         kind, len;
    logic [23:0] ra;
    reset       = 1'b0;
    spi_clk_in  = 1'b0;
    spi_select  = 1'b1;
    spi_data_in = 4'h0;
    host_addr   = '0;
    repeat (3) @(negedge clock);
    check("rst_oe", 32'(spi_data_oe), 32'(0));
    check("rst_dout", 32'(spi_data_out), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_cmd_error", 32'(cmd_error), 32'(0));
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // Fill the whole array so the model is fully known; upper address bits are ignored.
    wr_q.delete();
    for (int i = 0; i < 256; i++) wr_q.push_back(8'($urandom));
    write_txn(24'h5A0000, 1'b0);

    // Directed write and read at 0x10.
    wr_q = '{8'hA5, 8'h3C};
    write_txn(24'h000010, 1'b0);
    host_check("wr_lit_10", 8'h10, 8'hA5);
    host_check("wr_lit_11", 8'h11, 8'h3C);
    read_txn(24'h000010, 2);
    check("rd_lit_10", 32'({rd_q[0], rd_q[1]}), 32'hA53C);

    // Address wrap.
    wr_q = '{8'h11, 8'h22};
    write_txn(24'h0000FF, 1'b0);
    host_check("wrap_lit_ff", 8'hFF, 8'h11);
    host_check("wrap_lit_00", 8'h00, 8'h22);
    read_txn(24'h0000FF, 2);
    check("wrap_rd_lit", 32'({rd_q[0], rd_q[1]}), 32'h1122);

    // Abort after the first nibble leaves the location untouched.
    wr_q = '{~model_mem[8'h20]};
    write_txn(24'h000020, 1'b1);
    host_check("abort_keep_20", 8'h20, model_mem[8'h20]);
    read_txn(24'h000020, 1);

    // Unsupported command.
    bad_txn(8'h9F, 8);
    sweep("after_bad");

    // Asynchronous reset in the middle of a read.
    begin_txn();
    read_body(24'h000010, 1);
    chk_en = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    check("pre_rst_oe", 32'(spi_data_oe), 32'hF);
    reset = 1'b0;
    #1;
    check("async_rst_oe", 32'(spi_data_oe), 32'(0));
    check("async_rst_dout", 32'(spi_data_out), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_cmd_error", 32'(cmd_error), 32'(0));
    spi_select = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    wr_q = '{8'hC3};
    write_txn(24'h000040, 1'b0);
    host_check("post_rst_wr", 8'h40, 8'hC3);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 9));
      len  = int'($urandom_range(1, 6));
      ra   = 24'($urandom);
      if (kind == 0) begin
        do c = 8'($urandom); while (c == 8'h02 || c == 8'h03);
        bad_txn(c, int'($urandom_range(0, 10)));
      end else if (kind <= 5) begin
        wr_q.delete();
        for (int i = 0; i < len; i++) wr_q.push_back(8'($urandom));
        write_txn(ra, kind == 1);
      end else begin
        read_txn(ra, len);
      end
    end
    sweep("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
